axi_master_mo: RTL
==================

Name: axi_master_mo

Overview:
- Next-generation AXI4 master with independent read and write engines that run concurrently.
- Supports up to MAX_OUTSTANDING bursts in flight per direction.
- Write data, read data and write responses are streamed through valid/ready interfaces instead of a single shared command port.
- Sits between user DMA/accelerator logic and the AXI interconnect.

Parameters:
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, data width (power of 2, >=8)
- AXI_ID_WIDTH, 4, ID width
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width
- MAX_OUTSTANDING, 4, max in-flight bursts per direction (power of 2, 1..16)
- AXI_ID, 0, constant ID driven on AWID/ARID

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_cmd_valid/wr_cmd_ready  in/out  1/1  write command handshake
- wr_cmd_addr  in  AXI_ADDR_WIDTH  burst start address
- wr_cmd_len  in  8  beats-1
- wr_data_valid/wr_data_ready  in/out  1/1  write data stream
- wr_data, wr_strb  in  DATA/STRB  beat payload
- wr_resp_valid/wr_resp_ready  out/in  1/1  write response stream
- wr_resp  out  2  BRESP
- rd_cmd_valid/rd_cmd_ready  in/out  1/1  read command handshake
- rd_cmd_addr, rd_cmd_len  in  ADDR/8  as for write
- rd_data_valid/rd_data_ready  out/in  1/1  read data stream
- rd_data, rd_resp, rd_last  out  DATA/2/1  beat payload
- err_4k  out  1  sticky: a command crossed a 4 KB boundary
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  AXI4 master channels, full signal set including user/region/qos

Behaviour:
- Reset: all valid outputs 0, err_4k 0, counters 0, length FIFO empty. Command readies are 0 during reset and 1 after reset.
- Constant AXI fields:
  - AWID/ARID = AXI_ID
  - SIZE = log2(STRB_WIDTH)
  - BURST = INCR
  - lock, cache, prot, qos, region, user = 0
- AW path:
  - wr_cmd handshake loads the registered AWADDR/AWLEN and sets AWVALID the next cycle.
  - AWVALID and its payload are held stable until AWREADY.
  - wr_cmd_ready = !awvalid_q && wr_outstanding < MAX_OUTSTANDING && !len_fifo_full.
  - Same-cycle AW handshake plus new command is not allowed; throughput is one AW per 2 cycles.
- Length FIFO (depth MAX_OUTSTANDING) is pushed with AWLEN on the wr_cmd handshake, so W may run ahead of AW.
- W path:
  - m_axi_wvalid = wr_data_valid && !len_fifo_empty; wr_data_ready = m_axi_wready && !len_fifo_empty.
  - WDATA/WSTRB pass through combinationally.
  - WLAST = (beat_cnt == fifo_head). On a WLAST handshake, pop the FIFO and clear beat_cnt; otherwise increment beat_cnt on each handshake.
- wr_outstanding:
  - +1 on wr_cmd handshake, -1 on B handshake; both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows. A BVALID arriving with count 0 is ignored and bready is held 0.
- B path: wr_resp_valid = m_axi_bvalid when outstanding > 0; m_axi_bready = wr_resp_ready; wr_resp = BRESP.
- AR path:
  - Same register/hold scheme as AW.
  - rd_cmd_ready = !arvalid_q && rd_outstanding < MAX_OUTSTANDING.
  - rd_outstanding: +1 on rd_cmd handshake, -1 on R handshake with RLAST.
- R path: passthrough, rd_data_valid = RVALID, RREADY = rd_data_ready, rd_last = RLAST. No buffering, zero latency.
- 4 KB check: when (addr[11:0] + (len+1)*STRB_WIDTH) > 4096 on an accepted command, set err_4k; it stays set until reset. The command is still issued unchanged.
- Counter widths are clog2(MAX_OUTSTANDING)+1.
- Reset mid-burst: all state is cleared asynchronously; no AXI completion is required.

Decomposition:
- Package axi_master_pkg holds:
  - burst/resp enums (INCR, OKAY, SLVERR, ...)
  - AXI_SIZE function
  - 4 KB check function
- Sub-module axi_len_fifo: synchronous FIFO, parametrised WIDTH=8 and DEPTH, with push/pop/full/empty and head output. Reset is asynchronous active-low.

Test Plan:
- Single write, len=3, addr 0x100, AWREADY delayed 2 cycles:
  - AW held stable with len 3.
  - 4 W beats, WLAST on beat 4.
  - wr_resp OKAY forwarded.
- MAX_OUTSTANDING=4, 5 write commands back-to-back, BVALID withheld:
  - 4 AWs issue and wr_cmd_ready stays 0.
  - After one B handshake the 5th AW issues.
- W data presented before AW accepted (AWREADY=0 for 10 cycles), len=1:
  - Both beats transfer, WLAST on beat 2.
  - AW issues later.
- Concurrent read len=7 at 0x2000 and write len=0: both channels progress in the same cycles; rd_last asserts on beat 8.
- Command at addr 0xFF8, len=3, 32-bit data: err_4k rises one cycle after acceptance and stays high; the burst still issues.
- Reset asserted mid-read burst (beat 3 of 8): all valids drop immediately; after reset both command readies = 1 and counters = 0.

Source files
------------

// File: rtl/axi_master_mo_pkg.sv
// axi_master_pkg: shared AXI4 encodings and helpers for axi_master_mo
package axi_master_pkg;

   typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
   typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_e;

   localparam int USER_W = 1;

   function automatic logic [2:0] axi_size(input int strb_w);
      logic [2:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) if ((1 << i) == strb_w) s = 3'(i);
      return s;
   endfunction

   // True when the last byte of the burst lies beyond the 4 KB page holding its first byte
   function automatic logic crosses_4k(input logic [11:0] addr, input logic [7:0] len, input int strb_w);
      logic [31:0] end_b;
      end_b = 32'(addr) + (32'(len) + 32'd1) * 32'(strb_w);
      return end_b > 32'd4096;
   endfunction

endpackage

// File: rtl/axi_master_mo_len_fifo.sv
// axi_len_fifo: burst-length FIFO letting the W stream run ahead of AW
module axi_len_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = cnt_q == CW'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = do_push ? inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? inc(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/axi_master_mo.sv
// axi_master_mo: AXI4 master with independent, concurrently running read and write engines
module axi_master_mo
   import axi_master_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int AXI_DATA_WIDTH  = 32,
   parameter int AXI_ID_WIDTH    = 4,
   parameter int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int AXI_ID          = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      wr_cmd_valid_i,
   output logic                      wr_cmd_ready_o,
   input  logic [AXI_ADDR_WIDTH-1:0] wr_cmd_addr_i,
   input  logic [7:0]                wr_cmd_len_i,
   input  logic                      wr_data_valid_i,
   output logic                      wr_data_ready_o,
   input  logic [AXI_DATA_WIDTH-1:0] wr_data_i,
   input  logic [AXI_STRB_WIDTH-1:0] wr_strb_i,
   output logic                      wr_resp_valid_o,
   input  logic                      wr_resp_ready_i,
   output logic [1:0]                wr_resp_o,
   input  logic                      rd_cmd_valid_i,
   output logic                      rd_cmd_ready_o,
   input  logic [AXI_ADDR_WIDTH-1:0] rd_cmd_addr_i,
   input  logic [7:0]                rd_cmd_len_i,
   output logic                      rd_data_valid_o,
   input  logic                      rd_data_ready_i,
   output logic [AXI_DATA_WIDTH-1:0] rd_data_o,
   output logic [1:0]                rd_resp_o,
   output logic                      rd_last_o,
   output logic                      err_4k_o,
   output logic [AXI_ID_WIDTH-1:0]   m_axi_awid_o,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr_o,
   output logic [7:0]                m_axi_awlen_o,
   output logic [2:0]                m_axi_awsize_o,
   output logic [1:0]                m_axi_awburst_o,
   output logic                      m_axi_awlock_o,
   output logic [3:0]                m_axi_awcache_o,
   output logic [2:0]                m_axi_awprot_o,
   output logic [3:0]                m_axi_awqos_o,
   output logic [3:0]                m_axi_awregion_o,
   output logic [USER_W-1:0]         m_axi_awuser_o,
   output logic                      m_axi_awvalid_o,
   input  logic                      m_axi_awready_i,
   output logic [AXI_DATA_WIDTH-1:0] m_axi_wdata_o,
   output logic [AXI_STRB_WIDTH-1:0] m_axi_wstrb_o,
   output logic                      m_axi_wlast_o,
   output logic [USER_W-1:0]         m_axi_wuser_o,
   output logic                      m_axi_wvalid_o,
   input  logic                      m_axi_wready_i,
   input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid_i,
   input  logic [1:0]                m_axi_bresp_i,
   input  logic [USER_W-1:0]         m_axi_buser_i,
   input  logic                      m_axi_bvalid_i,
   output logic                      m_axi_bready_o,
   output logic [AXI_ID_WIDTH-1:0]   m_axi_arid_o,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr_o,
   output logic [7:0]                m_axi_arlen_o,
   output logic [2:0]                m_axi_arsize_o,
   output logic [1:0]                m_axi_arburst_o,
   output logic                      m_axi_arlock_o,
   output logic [3:0]                m_axi_arcache_o,
   output logic [2:0]                m_axi_arprot_o,
   output logic [3:0]                m_axi_arqos_o,
   output logic [3:0]                m_axi_arregion_o,
   output logic [USER_W-1:0]         m_axi_aruser_o,
   output logic                      m_axi_arvalid_o,
   input  logic                      m_axi_arready_i,
   input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid_i,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata_i,
   input  logic [1:0]                m_axi_rresp_i,
   input  logic                      m_axi_rlast_i,
   input  logic [USER_W-1:0]         m_axi_ruser_i,
   input  logic                      m_axi_rvalid_i,
   output logic                      m_axi_rready_o
);

   localparam int             CW   = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [CW-1:0]  MAXC = CW'(MAX_OUTSTANDING);
   localparam logic [2:0]     SIZE = axi_size(AXI_STRB_WIDTH);

   logic                      awvalid_q, awvalid_d, arvalid_q, arvalid_d;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [7:0]                awlen_q, awlen_d, arlen_q, arlen_d;
   logic [7:0]                beat_q, beat_d;
   logic [CW-1:0]             wr_out_q, wr_out_d, rd_out_q, rd_out_d;
   logic                      err_4k_q, err_4k_d;
   logic                      rdy_en_q;
   logic                      wr_cmd_hs, rd_cmd_hs, aw_hs, ar_hs, w_hs, b_hs, r_done;
   logic                      fifo_full, fifo_empty, wlast;
   logic [7:0]                fifo_head;
   logic                      unused_in;

   axi_len_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_len_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (wr_cmd_hs),
      .data_i  (wr_cmd_len_i),
      .pop_i   (w_hs && wlast),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // rdy_en_q keeps both command readies low while in reset
   assign wr_cmd_ready_o = rdy_en_q && !awvalid_q && wr_out_q < MAXC && !fifo_full;
   assign rd_cmd_ready_o = rdy_en_q && !arvalid_q && rd_out_q < MAXC;
   assign wr_cmd_hs      = wr_cmd_valid_i && wr_cmd_ready_o;
   assign rd_cmd_hs      = rd_cmd_valid_i && rd_cmd_ready_o;
   assign aw_hs          = awvalid_q && m_axi_awready_i;
   assign ar_hs          = arvalid_q && m_axi_arready_i;

   assign wlast           = beat_q == fifo_head;
   assign m_axi_wvalid_o  = wr_data_valid_i && !fifo_empty;
   assign wr_data_ready_o = m_axi_wready_i && !fifo_empty;
   assign m_axi_wdata_o   = wr_data_i;
   assign m_axi_wstrb_o   = wr_strb_i;
   assign m_axi_wlast_o   = wlast;
   assign m_axi_wuser_o   = '0;
   assign w_hs            = m_axi_wvalid_o && m_axi_wready_i;

   // A BVALID with nothing outstanding is stray and must not be acknowledged
   assign wr_resp_valid_o = m_axi_bvalid_i && wr_out_q != '0;
   assign m_axi_bready_o  = wr_resp_ready_i && wr_out_q != '0;
   assign wr_resp_o       = m_axi_bresp_i;
   assign b_hs            = m_axi_bvalid_i && m_axi_bready_o;

   assign rd_data_valid_o = m_axi_rvalid_i;
   assign m_axi_rready_o  = rd_data_ready_i;
   assign rd_data_o       = m_axi_rdata_i;
   assign rd_resp_o       = m_axi_rresp_i;
   assign rd_last_o       = m_axi_rlast_i;
   assign r_done          = m_axi_rvalid_i && rd_data_ready_i && m_axi_rlast_i && rd_out_q != '0;

   assign m_axi_awid_o     = AXI_ID_WIDTH'(AXI_ID);
   assign m_axi_awaddr_o   = awaddr_q;
   assign m_axi_awlen_o    = awlen_q;
   assign m_axi_awsize_o   = SIZE;
   assign m_axi_awburst_o  = INCR;
   assign m_axi_awlock_o   = 1'b0;
   assign m_axi_awcache_o  = '0;
   assign m_axi_awprot_o   = '0;
   assign m_axi_awqos_o    = '0;
   assign m_axi_awregion_o = '0;
   assign m_axi_awuser_o   = '0;
   assign m_axi_awvalid_o  = awvalid_q;

   assign m_axi_arid_o     = AXI_ID_WIDTH'(AXI_ID);
   assign m_axi_araddr_o   = araddr_q;
   assign m_axi_arlen_o    = arlen_q;
   assign m_axi_arsize_o   = SIZE;
   assign m_axi_arburst_o  = INCR;
   assign m_axi_arlock_o   = 1'b0;
   assign m_axi_arcache_o  = '0;
   assign m_axi_arprot_o   = '0;
   assign m_axi_arqos_o    = '0;
   assign m_axi_arregion_o = '0;
   assign m_axi_aruser_o   = '0;
   assign m_axi_arvalid_o  = arvalid_q;

   assign err_4k_o  = err_4k_q;
   assign unused_in = ^{m_axi_bid_i, m_axi_buser_i, m_axi_rid_i, m_axi_ruser_i};

   always_comb begin
      awvalid_d = wr_cmd_hs ? 1'b1 : (aw_hs ? 1'b0 : awvalid_q);
      awaddr_d  = wr_cmd_hs ? wr_cmd_addr_i : awaddr_q;
      awlen_d   = wr_cmd_hs ? wr_cmd_len_i : awlen_q;
      arvalid_d = rd_cmd_hs ? 1'b1 : (ar_hs ? 1'b0 : arvalid_q);
      araddr_d  = rd_cmd_hs ? rd_cmd_addr_i : araddr_q;
      arlen_d   = rd_cmd_hs ? rd_cmd_len_i : arlen_q;
      beat_d    = w_hs ? (wlast ? 8'd0 : beat_q + 8'd1) : beat_q;
      wr_out_d  = wr_out_q + CW'(wr_cmd_hs) - CW'(b_hs);
      rd_out_d  = rd_out_q + CW'(rd_cmd_hs) - CW'(r_done);
      err_4k_d  = err_4k_q
                | (wr_cmd_hs && crosses_4k(wr_cmd_addr_i[11:0], wr_cmd_len_i, AXI_STRB_WIDTH))
                | (rd_cmd_hs && crosses_4k(rd_cmd_addr_i[11:0], rd_cmd_len_i, AXI_STRB_WIDTH));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         awvalid_q <= 1'b0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         beat_q    <= '0;
         wr_out_q  <= '0;
         rd_out_q  <= '0;
         err_4k_q  <= 1'b0;
         rdy_en_q  <= 1'b0;
      end else begin
         awvalid_q <= awvalid_d;
         awaddr_q  <= awaddr_d;
         awlen_q   <= awlen_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         beat_q    <= beat_d;
         wr_out_q  <= wr_out_d;
         rd_out_q  <= rd_out_d;
         err_4k_q  <= err_4k_d;
         rdy_en_q  <= 1'b1;
      end
   end

endmodule
